// File: rtl/if_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared definitions for the instruction-fetch queue:
//   - EPOCH_W        : width of the redirect epoch tag carried with each request
//   - DEF_PC_STEP    : default sequential PC increment
//   - redir_e        : kind of redirect requested this cycle
//   - redir_sel()    : flush beats branch when both are asserted together
// ----------------------------------------------------------------------------
package if_fetch_queue_pkg;

   localparam int EPOCH_W     = 1;
   localparam int DEF_PC_STEP = 4;

   typedef enum logic [1:0] {
      REDIR_NONE   = 2'd0,
      REDIR_FLUSH  = 2'd1,
      REDIR_BRANCH = 2'd2
   } redir_e;

   function automatic redir_e redir_sel(input logic flush, input logic br_taken);
      redir_e r;
      r = REDIR_NONE;
      if (flush)         r = REDIR_FLUSH;
      else if (br_taken) r = REDIR_BRANCH;
      return r;
   endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous clear. Used as the prefetch queue and as
// the outstanding-request tag FIFO of if_fetch_queue.
// Ports:
//   clk, reset   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  write request; accepted when not full, or when full and
//                popping in the same cycle
//   pop          read request; ignored when empty
//   clear        empties the FIFO; wins over push and pop
//   rdata        head entry (undefined when empty)
//   full, empty, count  occupancy status
// ----------------------------------------------------------------------------
module sync_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;
   assign rdata = mem_q[rd_q];

   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = ptr_inc(wr_q);
         if (do_pop)  rd_d = ptr_inc(rd_q);
         if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
         else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage carries no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch stage: issues in-order I-cache requests, buffers responses
// in a prefetch queue and presents them to decode. Redirects (flush/branch)
// toggle an epoch bit so responses to requests issued before the redirect are
// dropped as they drain.
// Optional build macro: IF_FETCH_BYPASS_EN -- a current-epoch response that
// arrives while the queue is empty is presented to decode in the same cycle.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   stall                decode cannot accept; hold head entry
//   flush, new_pc        redirect to new_pc (wins over br_taken)
//   br_taken, br_addr    redirect to br_addr
//   ic_req, ic_addr      I-cache request and its address
//   ic_gnt               request accepted
//   ic_rvalid, ic_rinsn  in-order I-cache response
//   if_pc, if_insn, if_en instruction presented to decode
//   miss_stall           queue empty while requests are in flight
// ----------------------------------------------------------------------------
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int                ADDR_W          = 32,
   parameter int                INSN_W          = 32,
   parameter int                DEPTH           = 4,
   parameter int                MAX_OUTSTANDING = 2,
   parameter logic [ADDR_W-1:0] RESET_PC        = '0,
   parameter int                PC_STEP         = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic              ic_req,
   output logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_gnt,
   input  logic              ic_rvalid,
   input  logic [INSN_W-1:0] ic_rinsn,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INSN_W-1:0] if_insn,
   output logic              if_en,
   output logic              miss_stall
);

   localparam int QW  = ADDR_W + INSN_W;
   localparam int TW  = ADDR_W + EPOCH_W;
   localparam int QCW = $clog2(DEPTH + 1);
   localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic               active_q;

   redir_e             redir_kind;
   logic               redirect;
   logic [ADDR_W-1:0]  redir_pc;
   logic               accept;

   logic               tag_full, tag_empty;
   logic [TCW-1:0]     tag_count;
   logic [TW-1:0]      tag_rdata;
   logic [ADDR_W-1:0]  tag_pc;
   logic [EPOCH_W-1:0] tag_epoch;

   logic               q_push, q_pop, q_full, q_empty;
   logic [QCW-1:0]     q_count;
   logic [QW-1:0]      q_rdata;
   logic [ADDR_W-1:0]  head_pc;
   logic [INSN_W-1:0]  head_insn;

   logic               rsp_ok, rsp_fresh, consume;
   logic [31:0]        occupancy;

   assign redir_kind = redir_sel(flush, br_taken);
   assign redirect   = (redir_kind != REDIR_NONE);
   assign redir_pc   = (redir_kind == REDIR_FLUSH) ? new_pc : br_addr;

   // The tag FIFO count is the outstanding-request count. Queue entries plus
   // in-flight requests never exceed DEPTH, so every response has a slot.
   // active_q keeps ic_req low while reset is asserted and for the first
   // cycle after release.
   assign occupancy = 32'(q_count) + 32'(tag_count);
   assign ic_req    = active_q & (occupancy < 32'(DEPTH)) & ~tag_full & ~q_full & ~redirect;
   assign ic_addr   = fetch_pc_q;
   assign accept    = ic_req & ic_gnt;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok            = ic_rvalid & ~tag_empty;
   assign {tag_pc, tag_epoch} = tag_rdata;
   assign rsp_fresh         = rsp_ok & (tag_epoch == epoch_q);

   assign {head_pc, head_insn} = q_rdata;
   assign miss_stall           = q_empty & ~tag_empty;

`ifdef IF_FETCH_BYPASS_EN
   logic byp_hit;
   assign byp_hit = q_empty & rsp_fresh;
   assign if_en   = ~q_empty | byp_hit;
   assign if_pc   = ~q_empty ? head_pc   : (byp_hit ? tag_pc   : '0);
   assign if_insn = ~q_empty ? head_insn : (byp_hit ? ic_rinsn : '0);
   assign consume = if_en & ~stall & ~redirect;
   assign q_pop   = consume & ~q_empty;
   // A bypassed response consumed by decode never enters the queue.
   assign q_push  = rsp_fresh & ~(byp_hit & consume);
`else
   assign if_en   = ~q_empty;
   assign if_pc   = q_empty ? '0 : head_pc;
   assign if_insn = q_empty ? '0 : head_insn;
   assign consume = if_en & ~stall & ~redirect;
   assign q_pop   = consume;
   assign q_push  = rsp_fresh;
`endif

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      epoch_d    = epoch_q;
      if (redirect) begin
         fetch_pc_d = redir_pc;
         epoch_d    = ~epoch_q;
      end else if (accept) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         epoch_q    <= '0;
         active_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         epoch_q    <= epoch_d;
         active_q   <= 1'b1;
      end
   end

   // Tag FIFO is never cleared: in-flight responses must drain so their
   // stale epoch can be recognised.
   sync_fifo #(
      .WIDTH (TW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (rsp_ok),
      .clear (1'b0),
      .wdata ({fetch_pc_q, epoch_q}),
      .rdata (tag_rdata),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   // Cleared on redirect; a same-cycle response push is discarded by the clear.
   sync_fifo #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_pf_queue (
      .clk   (clk),
      .reset (reset),
      .push  (q_push),
      .pop   (q_pop),
      .clear (redirect),
      .wdata ({tag_pc, ic_rinsn}),
      .rdata (q_rdata),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = '0;
   logic        br_taken = 1'b0;
   logic [31:0] br_addr = '0;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_gnt = 1'b0;
   logic        ic_rvalid = 1'b0;
   logic [31:0] ic_rinsn = '0;
   logic [31:0] if_pc;
   logic [31:0] if_insn;
   logic        if_en;
   logic        miss_stall;

`ifdef IF_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   if_fetch_queue dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .new_pc     (new_pc),
      .br_taken   (br_taken),
      .br_addr    (br_addr),
      .ic_req     (ic_req),
      .ic_addr    (ic_addr),
      .ic_gnt     (ic_gnt),
      .ic_rvalid  (ic_rvalid),
      .ic_rinsn   (ic_rinsn),
      .if_pc      (if_pc),
      .if_insn    (if_insn),
      .if_en      (if_en),
      .miss_stall (miss_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } ent_t;

   pend_t       pend[$];   // requests accepted by the I-cache model
   ent_t        expq[$];   // scoreboard of entries expected at decode
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          lat = 1;
   int          first_en = -1;
   bit          act = 1'b0;
   bit          force_rsp = 1'b0;
   logic [31:0] exp_fetch = '0;

   function automatic logic [31:0] insn_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic bound_ok(input string tag, input bit ok);
      total++;
      assert (ok) else begin
         bad++;
         $error("FAIL %s: wait bound expired got 0 expected 1 (cycle %0d)", tag, cyc);
      end
   endtask

   // One clock cycle: drive the I-cache response, sample at the falling edge,
   // check against the model, then advance the model.
   task automatic step();
      bit    rsp_now, fresh, redir, exp_en, exp_req, consume, byp_used;
      ent_t  head;
      pend_t e;
      rsp_now   = (pend.size() > 0) && (pend[0].due <= cyc);
      ic_rvalid = rsp_now || force_rsp;
      ic_rinsn  = rsp_now ? insn_of(pend[0].addr) : 32'hBAD0_0BAD;
      #4;
      redir   = flush || br_taken;
      exp_req = act && ((expq.size() + pend.size()) < 4) && (pend.size() < 2) && !redir;
      chk("ic_req", 32'(ic_req), 32'(exp_req));
      if (ic_req) chk("ic_addr", ic_addr, exp_fetch);
      fresh  = rsp_now && !pend[0].stale;
      exp_en = (expq.size() != 0) || (BYP && fresh);
      chk("if_en", 32'(if_en), 32'(exp_en));
      chk("miss_stall", 32'(miss_stall), 32'((expq.size() == 0) && (pend.size() != 0)));
      if (if_en && first_en < 0) first_en = cyc;
      if (exp_en) begin
         if (expq.size() != 0) head = expq[0];
         else begin
            head.pc   = pend[0].addr;
            head.insn = insn_of(pend[0].addr);
         end
         chk("if_pc", if_pc, head.pc);
         chk("if_insn", if_insn, head.insn);
      end
      consume  = exp_en && !stall && !redir;
      byp_used = consume && (expq.size() == 0);
      if (consume && expq.size() != 0) void'(expq.pop_front());
      if (rsp_now) begin
         e = pend.pop_front();
         if (!e.stale && !redir && !byp_used)
            expq.push_back('{pc: e.addr, insn: insn_of(e.addr)});
      end
      if (ic_req && ic_gnt) begin
         pend.push_back('{addr: exp_fetch, due: cyc + lat, stale: 1'b0});
         exp_fetch = exp_fetch + 32'd4;
      end
      if (redir) begin
         expq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_fetch = flush ? new_pc : br_addr;
      end
      act = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ic_req"}, 32'(ic_req), 32'd0);
      chk({tag, "_if_en"}, 32'(if_en), 32'd0);
      chk({tag, "_if_pc"}, if_pc, 32'd0);
      chk({tag, "_if_insn"}, if_insn, 32'd0);
      chk({tag, "_miss_stall"}, 32'(miss_stall), 32'd0);
      chk({tag, "_ic_addr"}, ic_addr, 32'd0);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      reset = 1'b1;

      // 1: streaming fetch, 1-cycle responses
      ic_gnt = 1'b1;
      lat    = 1;
      repeat (12) step();
      chk("first_if_en_cycle", 32'(first_en), BYP ? 32'd2 : 32'd3);

      // 2: decode stalled, queue fills, nothing lost on release
      stall = 1'b1;
      repeat (10) step();
      stall = 1'b0;
      repeat (8) step();

      // 3: branch with two requests in flight
      lat = 3;
      n = 0;
      while (pend.size() != 2 && n < 10) begin step(); n++; end
      bound_ok("wait_two_outstanding", n < 10);
      br_taken = 1'b1;
      br_addr  = 32'h100;
      step();
      br_taken = 1'b0;
      lat = 1;
      repeat (10) step();

      // 4: flush and branch together, flush wins
      flush    = 1'b1;
      new_pc   = 32'h200;
      br_taken = 1'b1;
      br_addr  = 32'h300;
      step();
      flush    = 1'b0;
      br_taken = 1'b0;
      repeat (8) step();

      // 5: grant withheld on an empty queue, then a slow grant
      ic_gnt = 1'b0;
      n = 0;
      while ((pend.size() != 0 || expq.size() != 0) && n < 20) begin step(); n++; end
      bound_ok("wait_drain", n < 20);
      repeat (5) step();
      ic_gnt = 1'b1;
      lat    = 3;
      step();
      ic_gnt = 1'b0;
      repeat (5) step();

      // 6: reset mid-stream with requests outstanding
      ic_gnt = 1'b1;
      lat    = 2;
      repeat (4) step();
      bound_ok("outstanding_before_reset", pend.size() != 0);
      #2;
      reset     = 1'b0;
      ic_rvalid = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      pend.delete();
      expq.delete();
      exp_fetch = '0;
      act       = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      force_rsp = 1'b1;   // late response from before the reset
      step();
      force_rsp = 1'b0;
      lat = 1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
